// File: rtl/button_conditioner_if.sv
// Pushbutton bundle: raw buttons in, command pulses and levels out.
// master drives raw buttons; slave (conditioner) returns pulses/levels.
interface button_conditioner_if;
  logic       pause;
  logic       inc_hr;
  logic       inc_min;
  logic       dec_hr;
  logic       dec_min;
  logic       pause_p;
  logic       inc_hr_p;
  logic       inc_min_p;
  logic       dec_hr_p;
  logic       dec_min_p;
  logic [4:0] btn_level;

  modport master (
    output pause, inc_hr, inc_min, dec_hr, dec_min,
    input  pause_p, inc_hr_p, inc_min_p, dec_hr_p, dec_min_p,
    input  btn_level
  );

  modport slave (
    input  pause, inc_hr, inc_min, dec_hr, dec_min,
    output pause_p, inc_hr_p, inc_min_p, dec_hr_p, dec_min_p,
    output btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Sync, debounce, press pulse and auto-repeat for five pushbuttons.
// Ports: clk_100MHz, reset (sync, high), btn (slave: raw in, pulses/levels out).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  button_conditioner_if.slave   btn
);

  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RW = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST =
    RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  // bit order: {dec_min, dec_hr, inc_min, inc_hr, pause}
  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] lvl;
  logic [4:0] rise;
  logic [4:0] fall;
  logic [4:0] rpt_due;
  logic [4:0] cmd;
  logic [4:0] p_q;

  assign raw = {btn.dec_min, btn.dec_hr,
                btn.inc_min, btn.inc_hr,
                btn.pause};

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_db
    logic [DW-1:0] cnt;
    logic          lvl_r;
    logic          done;

    // level flips on the edge the count hits its last value
    assign done = (sync2[g] != lvl_r) &&
                  (cnt == DB_LAST);
    assign rise[g] = done & ~lvl_r;
    assign fall[g] = done &  lvl_r;
    assign lvl[g]  = lvl_r;

    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        cnt   <= '0;
        lvl_r <= 1'b0;
      end else if (sync2[g] == lvl_r) begin
        cnt <= '0;
      end else if (done) begin
        cnt   <= '0;
        lvl_r <= ~lvl_r;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  assign rpt_due[0] = 1'b0;

  for (genvar g = 1; g < 5; g++) begin : g_rpt
    rpt_state_t    st;
    logic [RW-1:0] rc;

    assign rpt_due[g] =
      ((st == DELAY)  && (rc == DLY_LAST)) ||
      ((st == REPEAT) && (rc == PER_LAST));

    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        st <= IDLE;
        rc <= '0;
      end else if (fall[g]) begin
        st <= IDLE;
        rc <= '0;
      end else begin
        unique case (st)
          IDLE: begin
            rc <= '0;
            if (rise[g]) st <= DELAY;
          end
          DELAY: begin
            if (rc == DLY_LAST) begin
              st <= REPEAT;
              rc <= '0;
            end else begin
              rc <= rc + RW'(1);
            end
          end
          REPEAT: begin
            if (rc == PER_LAST) rc <= '0;
            else rc <= rc + RW'(1);
          end
          default: begin
            st <= IDLE;
            rc <= '0;
          end
        endcase
      end
    end
  end

  // a repeat due on the release edge is dropped
  assign cmd = rise | (rpt_due & ~fall);

  // opposing commands on one field cancel
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q <= {cmd[4] & ~cmd[2],
              cmd[3] & ~cmd[1],
              cmd[2] & ~cmd[4],
              cmd[1] & ~cmd[3],
              cmd[0]};
    end
  end

  assign btn.pause_p   = p_q[0];
  assign btn.inc_hr_p  = p_q[1];
  assign btn.inc_min_p = p_q[2];
  assign btn.dec_hr_p  = p_q[3];
  assign btn.dec_min_p = p_q[4];
  assign btn.btn_level = lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DB=4, DELAY=10, PERIOD=5).
// Drives and samples 1 time unit after each rising edge.
module tb_button_conditioner;

  logic clk_100MHz = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  button_conditioner_if btn ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .btn        (btn.slave)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  logic [4:0] pv;
  assign pv = {btn.dec_min_p, btn.dec_hr_p,
               btn.inc_min_p, btn.inc_hr_p,
               btn.pause_p};

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    btn.pause   = 1'b0;
    btn.inc_hr  = 1'b0;
    btn.inc_min = 1'b0;
    btn.dec_hr  = 1'b0;
    btn.dec_min = 1'b0;

    // reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_pulses", pv, 5'b0);
    chk("rst_level", btn.btn_level, 5'b0);
    reset = 1'b0;
    tick();
    tick();

    // single press on inc_hr, held 8 edges
    btn.inc_hr = 1'b1;
    for (int j = 0; j < 25; j++) begin
      tick();
      if (j == 7) btn.inc_hr = 1'b0;
      chk($sformatf("a_p%0d", j), pv,
          (j == 5) ? 5'b00010 : 5'b0);
      chk($sformatf("a_l%0d", j), btn.btn_level,
          (j >= 5 && j <= 12) ? 5'b00010 : 5'b0);
    end

    // pause glitching 3 high / 3 low
    for (int j = 0; j < 30; j++) begin
      btn.pause = ((j / 3) % 2 == 0);
      tick();
      chk($sformatf("b_p%0d", j), pv, 5'b0);
      chk($sformatf("b_l%0d", j), btn.btn_level, 5'b0);
    end
    btn.pause = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    chk("b_end", btn.btn_level, 5'b0);

    // dec_min held 40 edges: press + repeats,
    // repeat due on release edge (j=45) dropped
    btn.dec_min = 1'b1;
    for (int j = 0; j < 56; j++) begin
      tick();
      if (j == 39) btn.dec_min = 1'b0;
      chk($sformatf("c_p%0d", j), pv,
          (j == 5 || (j >= 15 && j <= 40 &&
                      j % 5 == 0)) ? 5'b10000 : 5'b0);
      chk($sformatf("c_l%0d", j), btn.btn_level,
          (j >= 5 && j <= 44) ? 5'b10000 : 5'b0);
    end

    // inc_min vs dec_min conflict
    btn.inc_min = 1'b1;
    btn.dec_min = 1'b1;
    for (int j = 0; j < 31; j++) begin
      tick();
      if (j == 19) begin
        btn.inc_min = 1'b0;
        btn.dec_min = 1'b0;
      end
      chk($sformatf("d_p%0d", j), pv, 5'b0);
      chk($sformatf("d_l%0d", j), btn.btn_level,
          (j >= 5 && j <= 24) ? 5'b10100 : 5'b0);
    end

    // inc_hr and inc_min together
    btn.inc_hr  = 1'b1;
    btn.inc_min = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 5) begin
        btn.inc_hr  = 1'b0;
        btn.inc_min = 1'b0;
      end
      chk($sformatf("e_p%0d", j), pv,
          (j == 5) ? 5'b00110 : 5'b0);
      chk($sformatf("e_l%0d", j), btn.btn_level,
          (j >= 5 && j <= 10) ? 5'b00110 : 5'b0);
    end

    // dec_hr held, reset during DELAY
    btn.dec_hr = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("f_p%0d", j), pv,
          (j == 5) ? 5'b01000 : 5'b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("f_rst_p", pv, 5'b0);
    chk("f_rst_l", btn.btn_level, 5'b0);
    for (int i = 0; i < 23; i++) begin
      tick();
      chk($sformatf("f2_p%0d", i), pv,
          (i == 5 || i == 15 || i == 20) ?
          5'b01000 : 5'b0);
      chk($sformatf("f2_l%0d", i), btn.btn_level,
          (i >= 5) ? 5'b01000 : 5'b0);
    end
    btn.dec_hr = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    chk("f_end_p", pv, 5'b0);
    chk("f_end_l", btn.btn_level, 5'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
